// File: rtl/arm_pipelined_pkg.sv
// Shared decode-stage types and constants for the pipelined ARM core:
// sequencer states, block-addressing modes and instruction field positions.
package arm_pipelined_pkg;

  localparam logic [1:0] OP_MEMORY_MULTI = 2'b10;

  localparam int FUNCT_BLOCK = 5;  // 0 selects LDM/STM within the memory-multi op
  localparam int FUNCT_P     = 4;
  localparam int FUNCT_U     = 3;
  localparam int FUNCT_S     = 2;
  localparam int FUNCT_W     = 1;
  localparam int FUNCT_L     = 0;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t SEQ_IDLE = 2'd0;
  localparam seq_state_t SEQ_XFER = 2'd1;
  localparam seq_state_t SEQ_WB   = 2'd2;

  // Encoded as {P,U} so the mode falls straight out of the Funct field.
  typedef enum logic [1:0] {
    MODE_DA = 2'b00,
    MODE_IA = 2'b01,
    MODE_DB = 2'b10,
    MODE_IB = 2'b11
  } blk_mode_e;

  function automatic blk_mode_e block_mode(input logic p, input logic u);
    return blk_mode_e'({p, u});
  endfunction

endpackage

// File: rtl/arm_block_transfer_sequencer_if.sv
// Decode-side instruction inputs and micro-op outputs of the block-transfer
// sequencer; master drives the instruction, slave is the sequencer.
interface arm_block_transfer_sequencer_if #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS),
  parameter int OFFSET_W  = 12
);
  logic                 i_Valid;
  logic [1:0]           i_Op;
  logic [5:0]           i_Funct;
  logic [REG_IDX_W-1:0] i_Rn;
  logic [NUM_REGS-1:0]  i_Reg_List;
  logic                 i_Stall;
  logic                 i_Flush;

  logic                 o_Ready;
  logic                 o_Uop_Valid;
  logic [REG_IDX_W-1:0] o_Uop_Rd;
  logic [REG_IDX_W-1:0] o_Uop_Rn;
  logic [OFFSET_W-1:0]  o_Uop_Offset;
  logic                 o_Uop_Load;
  logic                 o_Uop_Writeback;
  logic                 o_Uop_Last;

  modport master (
    output i_Valid, i_Op, i_Funct, i_Rn, i_Reg_List, i_Stall, i_Flush,
    input  o_Ready, o_Uop_Valid, o_Uop_Rd, o_Uop_Rn, o_Uop_Offset,
           o_Uop_Load, o_Uop_Writeback, o_Uop_Last
  );

  modport slave (
    input  i_Valid, i_Op, i_Funct, i_Rn, i_Reg_List, i_Stall, i_Flush,
    output o_Ready, o_Uop_Valid, o_Uop_Rd, o_Uop_Rn, o_Uop_Offset,
           o_Uop_Load, o_Uop_Writeback, o_Uop_Last
  );

endinterface

// File: rtl/arm_reg_list_priority_enc.sv
// Lowest-set-bit encoder over an LDM/STM register list; o_any flags a
// non-empty list.
module arm_reg_list_priority_enc #(
  parameter int NUM_REGS  = 16,
  parameter int REG_IDX_W = $clog2(NUM_REGS)
) (
  input  logic [NUM_REGS-1:0]  i_list,
  output logic [REG_IDX_W-1:0] o_idx,
  output logic                 o_any
);

  // Scan high to low so the lowest set bit is the last one written.
  always_comb begin
    o_idx = '0;
    o_any = 1'b0;
    for (int k = NUM_REGS - 1; k >= 0; k--) begin
      if (i_list[k]) begin
        o_idx = REG_IDX_W'(k);
        o_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/arm_block_transfer_sequencer.sv
// Splits LDM/STM into single-register load/store micro-ops, one per unstalled
// cycle. Define ARM_BLOCK_WRITEBACK_EN to emit the trailing base-writeback micro-op.
module arm_block_transfer_sequencer
  import arm_pipelined_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_IDX_W  = $clog2(NUM_REGS),
  parameter int OFFSET_W   = 12,
  parameter int WORD_BYTES = 4
) (
  input logic                           i_CLK,
  input logic                           i_NRESET,
  arm_block_transfer_sequencer_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_REGS + 1);
`ifdef ARM_BLOCK_WRITEBACK_EN
  localparam logic WB_EN = 1'b1;
`else
  localparam logic WB_EN = 1'b0;
`endif

  seq_state_t                 state_q, state_d;
  logic [NUM_REGS-1:0]        list_q, list_d;
  logic [REG_IDX_W-1:0]       rn_q, rn_d;
  logic                       u_q, u_d, w_q, w_d, l_q, l_d;
  logic [CNT_W-1:0]           count_q, count_d;
  logic signed [OFFSET_W-1:0] offset_q, offset_d;

  logic [REG_IDX_W-1:0]       enc_idx;
  logic                       enc_any;
  logic                       accept, last_reg;
  logic [NUM_REGS-1:0]        list_rest;
  logic [CNT_W-1:0]           in_count;
  logic signed [OFFSET_W-1:0] stride, in_bytes, start_offset, total_bytes;
  logic                       unused_s_bit;

  arm_reg_list_priority_enc #(
    .NUM_REGS  (NUM_REGS),
    .REG_IDX_W (REG_IDX_W)
  ) u_enc (
    .i_list (list_q),
    .o_idx  (enc_idx),
    .o_any  (enc_any)
  );

  assign unused_s_bit = bus.i_Funct[FUNCT_S];
  assign stride       = OFFSET_W'(WORD_BYTES);
  assign in_bytes     = OFFSET_W'(in_count) * stride;
  assign total_bytes  = OFFSET_W'(count_q) * stride;
  assign list_rest    = list_q & (list_q - NUM_REGS'(1));
  assign last_reg     = (list_rest == '0);
  assign accept       = bus.i_Valid & (bus.i_Op == OP_MEMORY_MULTI) & ~bus.i_Funct[FUNCT_BLOCK]
                      & ~bus.i_Stall & ~bus.i_Flush;

  always_comb begin
    in_count = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      in_count = in_count + CNT_W'(bus.i_Reg_List[k]);
    end
  end

  // Decrement modes still walk registers upward, so they start at the lowest address.
  always_comb begin
    case (block_mode(bus.i_Funct[FUNCT_P], bus.i_Funct[FUNCT_U]))
      MODE_IA: start_offset = '0;
      MODE_IB: start_offset = stride;
      MODE_DA: start_offset = stride - in_bytes;
      default: start_offset = -in_bytes;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    list_d   = list_q;
    rn_d     = rn_q;
    u_d      = u_q;
    w_d      = w_q;
    l_d      = l_q;
    count_d  = count_q;
    offset_d = offset_q;
    if (bus.i_Flush) begin
      state_d = SEQ_IDLE;
    end else begin
      case (state_q)
        SEQ_IDLE: begin
          if (accept) begin
            rn_d    = bus.i_Rn;
            u_d     = bus.i_Funct[FUNCT_U];
            w_d     = bus.i_Funct[FUNCT_W] & WB_EN;
            l_d     = bus.i_Funct[FUNCT_L];
            list_d  = bus.i_Reg_List;
            count_d = in_count;
            if (in_count != '0) begin
              state_d  = SEQ_XFER;
              offset_d = start_offset;
            end else if (w_d) begin
              state_d  = SEQ_WB;
              offset_d = '0;
            end
          end
        end
        SEQ_XFER: begin
          if (!bus.i_Stall) begin
            list_d   = list_rest;
            offset_d = offset_q + stride;
            if (last_reg || !enc_any) begin
              state_d = SEQ_IDLE;
              if (w_q) begin
                state_d  = SEQ_WB;
                offset_d = u_q ? total_bytes : -total_bytes;
              end
            end
          end
        end
`ifdef ARM_BLOCK_WRITEBACK_EN
        SEQ_WB: begin
          if (!bus.i_Stall) state_d = SEQ_IDLE;
        end
`endif
        default: state_d = SEQ_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_CLK) begin
    if (!i_NRESET) begin
      state_q  <= SEQ_IDLE;
      list_q   <= '0;
      rn_q     <= '0;
      u_q      <= 1'b0;
      w_q      <= 1'b0;
      l_q      <= 1'b0;
      count_q  <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      list_q   <= list_d;
      rn_q     <= rn_d;
      u_q      <= u_d;
      w_q      <= w_d;
      l_q      <= l_d;
      count_q  <= count_d;
      offset_q <= offset_d;
    end
  end

  always_comb begin
    bus.o_Ready         = (state_q == SEQ_IDLE);
    bus.o_Uop_Valid     = 1'b0;
    bus.o_Uop_Rd        = '0;
    bus.o_Uop_Rn        = '0;
    bus.o_Uop_Offset    = '0;
    bus.o_Uop_Load      = 1'b0;
    bus.o_Uop_Writeback = 1'b0;
    bus.o_Uop_Last      = 1'b0;
    if (state_q == SEQ_XFER) begin
      bus.o_Uop_Valid  = enc_any;
      bus.o_Uop_Rd     = enc_idx;
      bus.o_Uop_Rn     = rn_q;
      bus.o_Uop_Offset = offset_q;
      bus.o_Uop_Load   = l_q;
      bus.o_Uop_Last   = last_reg & ~w_q;
    end
`ifdef ARM_BLOCK_WRITEBACK_EN
    else if (state_q == SEQ_WB) begin
      bus.o_Uop_Valid     = 1'b1;
      bus.o_Uop_Rd        = rn_q;
      bus.o_Uop_Rn        = rn_q;
      bus.o_Uop_Offset    = offset_q;
      bus.o_Uop_Writeback = 1'b1;
      bus.o_Uop_Last      = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_arm_block_transfer_sequencer.sv
// Directed bench for the block-transfer sequencer: hand-computed micro-op
// streams for LDM/STM modes, stall, flush, reset and ignored instructions.
module tb_arm_block_transfer_sequencer;

  logic clk = 1'b0;
  logic nreset;
  int   n_checks = 0;
  int   n_fail   = 0;

  arm_block_transfer_sequencer_if #(.NUM_REGS(16), .OFFSET_W(12)) bus ();

  arm_block_transfer_sequencer #(
    .NUM_REGS   (16),
    .OFFSET_W   (12),
    .WORD_BYTES (4)
  ) dut (
    .i_CLK    (clk),
    .i_NRESET (nreset),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string name, input logic [1:0] op, input logic [5:0] funct,
                       input logic [3:0] rn, input logic [15:0] list);
    $display("txn %s op=%b funct=%b rn=%0d list=%h", name, op, funct, rn, list);
    bus.i_Valid    = 1'b1;
    bus.i_Op       = op;
    bus.i_Funct    = funct;
    bus.i_Rn       = rn;
    bus.i_Reg_List = list;
    tick();
    bus.i_Valid    = 1'b0;
  endtask

  task automatic exp_uop(input string tag, input int rd, input int rn, input int off,
                         input int load, input int wb, input int last);
    check_eq({tag, ".ready"}, int'(bus.o_Ready), 0);
    check_eq({tag, ".valid"}, int'(bus.o_Uop_Valid), 1);
    check_eq({tag, ".rd"}, int'(bus.o_Uop_Rd), rd);
    check_eq({tag, ".rn"}, int'(bus.o_Uop_Rn), rn);
    check_eq({tag, ".offset"}, int'($signed(bus.o_Uop_Offset)), off);
    check_eq({tag, ".load"}, int'(bus.o_Uop_Load), load);
    check_eq({tag, ".wb"}, int'(bus.o_Uop_Writeback), wb);
    check_eq({tag, ".last"}, int'(bus.o_Uop_Last), last);
  endtask

  task automatic exp_idle(input string tag);
    check_eq({tag, ".ready"}, int'(bus.o_Ready), 1);
    check_eq({tag, ".valid"}, int'(bus.o_Uop_Valid), 0);
    check_eq({tag, ".rd"}, int'(bus.o_Uop_Rd), 0);
    check_eq({tag, ".rn"}, int'(bus.o_Uop_Rn), 0);
    check_eq({tag, ".offset"}, int'(bus.o_Uop_Offset), 0);
    check_eq({tag, ".load"}, int'(bus.o_Uop_Load), 0);
    check_eq({tag, ".wb"}, int'(bus.o_Uop_Writeback), 0);
    check_eq({tag, ".last"}, int'(bus.o_Uop_Last), 0);
  endtask

  initial begin
    nreset         = 1'b0;
    bus.i_Valid    = 1'b0;
    bus.i_Op       = 2'b00;
    bus.i_Funct    = 6'b0;
    bus.i_Rn       = 4'd0;
    bus.i_Reg_List = 16'h0;
    bus.i_Stall    = 1'b0;
    bus.i_Flush    = 1'b0;
    repeat (2) tick();
    exp_idle("reset");
    nreset = 1'b1;
    tick();

    issue("LDMIA r0!,{r1,r3,r7}", 2'b10, 6'b001011, 4'd0, 16'h008A);
    exp_uop("ldmia.0", 1, 0, 0, 1, 0, 0);
    tick();
    exp_uop("ldmia.1", 3, 0, 4, 1, 0, 0);
    tick();
`ifdef ARM_BLOCK_WRITEBACK_EN
    exp_uop("ldmia.2", 7, 0, 8, 1, 0, 0);
    tick();
    exp_uop("ldmia.wb", 0, 0, 12, 0, 1, 1);
    tick();
`else
    exp_uop("ldmia.2", 7, 0, 8, 1, 0, 1);
    tick();
`endif
    exp_idle("ldmia.done");

    issue("STMDB r13!,{r4,r5}", 2'b10, 6'b010010, 4'd13, 16'h0030);
    exp_uop("stmdb.0", 4, 13, -8, 0, 0, 0);
    tick();
`ifdef ARM_BLOCK_WRITEBACK_EN
    exp_uop("stmdb.1", 5, 13, -4, 0, 0, 0);
    tick();
    exp_uop("stmdb.wb", 13, 13, -8, 0, 1, 1);
    tick();
`else
    exp_uop("stmdb.1", 5, 13, -4, 0, 0, 1);
    tick();
`endif
    exp_idle("stmdb.done");

    issue("LDMIB r2,{r0}", 2'b10, 6'b011001, 4'd2, 16'h0001);
    exp_uop("ldmib.0", 0, 2, 4, 1, 0, 1);
    tick();
    exp_idle("ldmib.done");

    issue("LDMDA r1,{r2,r6,r9} with stall", 2'b10, 6'b000001, 4'd1, 16'h0244);
    exp_uop("ldmda.0", 2, 1, -8, 1, 0, 0);
    tick();
    exp_uop("ldmda.1", 6, 1, -4, 1, 0, 0);
    bus.i_Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      exp_uop($sformatf("ldmda.stall%0d", i), 6, 1, -4, 1, 0, 0);
    end
    bus.i_Stall = 1'b0;
    tick();
    exp_uop("ldmda.2", 9, 1, 0, 1, 0, 1);
    tick();
    exp_idle("ldmda.done");

    issue("LDMIA r0,{r1,r3,r7} flushed", 2'b10, 6'b001001, 4'd0, 16'h008A);
    exp_uop("flush.0", 1, 0, 0, 1, 0, 0);
    tick();
    exp_uop("flush.1", 3, 0, 4, 1, 0, 0);
    bus.i_Flush = 1'b1;
    tick();
    bus.i_Flush = 1'b0;
    exp_idle("flush.done");

    issue("LDMIA r0,{r1,r3,r7} reset", 2'b10, 6'b001001, 4'd0, 16'h008A);
    tick();
    exp_uop("rst.1", 3, 0, 4, 1, 0, 0);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    exp_idle("rst.done");

    bus.i_Stall = 1'b1;
    issue("LDMIA r3,{r1} under stall", 2'b10, 6'b001001, 4'd3, 16'h0002);
    bus.i_Stall = 1'b0;
    exp_idle("stall_accept");

    issue("LDMIA r5!,{} empty", 2'b10, 6'b001011, 4'd5, 16'h0000);
`ifdef ARM_BLOCK_WRITEBACK_EN
    exp_uop("empty.wb", 5, 5, 0, 0, 1, 1);
    tick();
`endif
    exp_idle("empty.done");

    issue("Op=01 single transfer", 2'b01, 6'b001011, 4'd4, 16'h00FF);
    exp_idle("nonblock.op");
    issue("Op=10 Funct[5]=1", 2'b10, 6'b101011, 4'd4, 16'h00FF);
    exp_idle("nonblock.funct5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
